// File: rtl/bus_arbiter_wrr.sv
// Weighted round-robin bus arbiter with active-low request/lock/grant and per-master enable.
// Latency: one cycle from request to grant; handover is a registered one-cycle pulse per owner change.
// Backpressure: none; an unlocked owner is preempted after MAX_HOLD consecutive requesting cycles.
module bus_arbiter_wrr #(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_HOLD    = 16,
    localparam int OWNER_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int CNT_W      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req_,
    input  logic [NUM_MASTERS-1:0] lock_,
    input  logic [NUM_MASTERS-1:0] en,
    output logic [NUM_MASTERS-1:0] grnt_,
    output logic [OWNER_W-1:0]     owner,
    output logic                   handover
);

    // Last hold-counter value of a window; unused when holding is unlimited.
    localparam logic [CNT_W-1:0] HC_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    logic [NUM_MASTERS-1:0] r;
    logic [NUM_MASTERS-1:0] l;
    logic [CNT_W-1:0]       hc;
    logic                   expired;
    logic [OWNER_W-1:0]     nxt_owner;
    logic [CNT_W-1:0]       nxt_hc;
    logic                   nxt_handover;
    logic                   found;
    logic [OWNER_W-1:0]     cand;
    logic [OWNER_W-1:0]     hit;

    // A disabled master's request and lock are invisible to arbitration.
    assign r = en & ~req_;
    assign l = en & ~lock_;

    // Window ends on the last counted cycle unless the owner is holding its lock.
    assign expired = (MAX_HOLD != 0) && (hc == HC_LAST) && !l[owner];

    // Grant follows the owner register directly, also while parked.
    always_comb begin
        grnt_        = '1;
        grnt_[owner] = 1'b0;
    end

    // Round-robin search starting just after the current owner, owner excluded.
    always_comb begin
        found = 1'b0;
        hit   = owner;
        cand  = owner;
        for (int k = 1; k < NUM_MASTERS; k++) begin
            cand = OWNER_W'((int'(owner) + k) % NUM_MASTERS);
            if (!found && r[cand]) begin
                found = 1'b1;
                hit   = cand;
            end
        end
    end

    // Next-state decision: keep and count, rotate, restart window, or park.
    always_comb begin
        nxt_owner    = owner;
        nxt_hc       = '0;
        nxt_handover = 1'b0;
        if (r[owner] && !expired) begin
            if (l[owner] || MAX_HOLD == 0 || hc == HC_LAST) begin
                nxt_hc = hc;
            end else begin
                nxt_hc = hc + 1'b1;
            end
        end else if (found) begin
            nxt_owner    = hit;
            nxt_handover = 1'b1;
        end
    end

    // Arbitration state; reset discards any hold window or lock in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= '0;
            hc       <= '0;
            handover <= 1'b0;
        end else begin
            owner    <= nxt_owner;
            hc       <= nxt_hc;
            handover <= nxt_handover;
        end
    end

endmodule

// File: doc/bus_arbiter_wrr.md
BUS_ARBITER_WRR -- requirements
Module: bus_arbiter_wrr

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, meaning the number of bus masters, legal range 2..16.
REQ-002 SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of consecutive requesting cycles an unlocked owner keeps the bus; 0 means unlimited.
REQ-003 SHALL have localparam OWNER_W = max(1, clog2(NUM_MASTERS)) and localparam CNT_W = max(1, clog2(MAX_HOLD+1)).
REQ-004 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_  input  NUM_MASTERS  per-master bus request, active-low; bit i belongs to master i.
REQ-007 SHALL have port lock_  input  NUM_MASTERS  per-master lock, active-low; it has an effect only for the current owner while that owner's request is asserted.
REQ-008 SHALL have port en  input  NUM_MASTERS  per-master enable, active-high; when en[i] is 0, req_[i] and lock_[i] are treated as deasserted.
REQ-009 SHALL have port grnt_  output  NUM_MASTERS  per-master grant, active-low, one-hot-low.
REQ-010 SHALL have port owner  output  OWNER_W  index of the current bus owner.
REQ-011 SHALL have port handover  output  1  one-cycle pulse, high in the first cycle after the owner changes.

Function
REQ-012 SHALL drive grnt_ combinationally from owner: grnt_[owner]=0 and all other bits 1, at all times, including while the bus is parked.
REQ-013 SHALL define effective request r[i] = en[i] & ~req_[i] and effective lock l[i] = en[i] & ~lock_[i].
REQ-014 SHALL keep an internal hold counter hc (CNT_W bits) that counts the owner's consecutive requesting cycles; hc = 0 in the first cycle after any owner change.
REQ-015 SHALL define "expired" as: MAX_HOLD != 0 && hc == MAX_HOLD-1 && !l[owner].
REQ-016 SHALL, when r[owner] && !expired, keep the owner; hc increments, saturating at MAX_HOLD-1 (hc is held unchanged while l[owner]).
REQ-017 SHALL, when !r[owner] || expired, search r[] in round-robin order owner+1, owner+2, ... wrapping modulo NUM_MASTERS and excluding owner itself; on the first hit the new owner is latched, hc is set to 0 and handover is set to 1 in the next cycle.
REQ-018 SHALL, when expired and no other master requests, keep the owner and set hc to 0 (a new hold window starts).
REQ-019 SHALL, when no master requests (all r=0), keep the owner (parking), set hc to 0 and set handover to 0.
REQ-020 SHALL give a one-cycle grant latency: a request raised while the bus is free produces grnt_ in the next cycle.
REQ-021 SHALL ensure that with MAX_HOLD=M and no locks, a continuously requesting master waits at most (NUM_MASTERS-1)*M cycles for a grant.
REQ-022 SHALL ignore a lock asserted by a non-owner, and SHALL make the owner subject to expiry starting on the cycle after it releases its lock.
REQ-023 SHALL treat deassertion of en[owner] as an owner request drop and rotate per REQ-017 in the same cycle.
REQ-024 SHALL keep owner unchanged when multiple requests arrive in the same cycle as the owner's request drop, except as selected by the REQ-017 order (e.g. owner=3, r=0b0110 -> next owner 1).
REQ-025 SHALL make handover a registered output, high for exactly one cycle per owner change.

Reset
REQ-026 SHALL, when reset=1 at a rising clk edge, set owner=0, hc=0 and handover=0, giving grnt_ = all ones except bit0=0.
REQ-027 SHALL give reset priority over all arbitration in that cycle, and SHALL discard any partial hold window or lock at reset.
REQ-028 SHALL resume arbitration on the first clk edge after reset deasserts.

Verification (NUM_MASTERS=4, MAX_HOLD=4, en=4'b1111 unless stated)
REQ-029 SHALL be covered by: reset, req_=4'b1111 -> owner=0, grnt_=4'b1110, handover=0, stable for 10 cycles.
REQ-030 SHALL be covered by: from owner=0 idle, req_=4'b1011 -> next cycle owner=2, grnt_=4'b1011, handover=1 for one cycle, then 0.
REQ-031 SHALL be covered by: req_=4'b0000 held constant from owner=0 -> owner sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0..., with handover pulses on each change.
REQ-032 SHALL be covered by: owner=1 with lock_=4'b1101 and req_=4'b0000 held for 20 cycles -> owner stays 1; on lock release -> owner 2 within 4 cycles.
REQ-033 SHALL be covered by: owner=2, req_=4'b1010, en=4'b1011 -> owner moves to 0 in the next cycle (master 2 is masked); master 2 is not granted while en[2]=0.
REQ-034 SHALL be covered by: reset asserted mid-hold (owner=3, hc=2) -> next cycle owner=0, grnt_=4'b1110, handover=0; after release with req_=4'b0111, owner=3 after one cycle with hc restarting from 0.
